// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD subtractor: FSM states and decimal constants.
// The NEG state exists only when BCD_SUB_SIGNMAG_EN is defined.
package bcd_pkg;

   localparam logic [3:0] BCD_MAX   = 4'd9;
   localparam int         BCD_RADIX = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
`ifdef BCD_SUB_SIGNMAG_EN
      NEG  = 2'd2,
`endif
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtract step: d = x - y - bin, with a decimal wrap on underflow.
// Purely combinational, zero latency.
// No handshake; the caller sequences the digits.
module bcd_digit_sub
   import bcd_pkg::*;
(
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       bin,
   output logic [3:0] d,
   output logic       bout,
   output logic       inv
);

   logic [5:0] t;

   always_comb begin
      t    = {2'b00, x} - {2'b00, y} - {5'b00000, bin};
      bout = t[5];
      d    = bout ? 4'(t + 6'(BCD_RADIX)) : t[3:0];
      inv  = (x > BCD_MAX) || (y > BCD_MAX);
   end

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor (a - b), LSD first, one digit per cycle.
// Latency DIGITS cycles, or 2*DIGITS when BCD_SUB_SIGNMAG_EN adds the magnitude pass.
// Single operation in flight: in_ready low until the result is taken with out_ready.
module bcd_sub_serial
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   diff,
   output logic                  borrow,
   output logic                  err
);

   localparam int             IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0]  LAST = IW'(DIGITS - 1);

   state_t                state, nxt_state;
   logic [4*DIGITS-1:0]   a_r, b_r, work, nxt_a, nxt_b, nxt_work, nxt_diff;
   logic [IW-1:0]         idx, nxt_idx;
   logic                  brw, nxt_brw, err_acc, nxt_err_acc, fin_err;
   logic                  nxt_in_ready, nxt_out_valid, nxt_borrow, nxt_err;
   logic [3:0]            dx, dy, dd;
   logic                  dbout, dinv;

   bcd_digit_sub u_digit (
      .x    (dx),
      .y    (dy),
      .bin  (brw),
      .d    (dd),
      .bout (dbout),
      .inv  (dinv)
   );

   // One digit-step instance serves both passes; NEG subtracts the working digit from zero.
   always_comb begin
      dx = a_r[int'(idx)*4 +: 4];
      dy = b_r[int'(idx)*4 +: 4];
`ifdef BCD_SUB_SIGNMAG_EN
      if (state == NEG) begin
         dx = 4'd0;
         dy = work[int'(idx)*4 +: 4];
      end
`endif
   end

   always_comb begin
      nxt_state     = state;
      nxt_a         = a_r;
      nxt_b         = b_r;
      nxt_work      = work;
      nxt_idx       = idx;
      nxt_brw       = brw;
      nxt_err_acc   = err_acc;
      nxt_in_ready  = in_ready;
      nxt_out_valid = out_valid;
      nxt_diff      = diff;
      nxt_borrow    = borrow;
      nxt_err       = err;
      fin_err       = err_acc | dinv;
      case (state)
         IDLE: begin
            if (in_valid) begin
               nxt_a        = a;
               nxt_b        = b;
               nxt_brw      = 1'b0;
               nxt_idx      = '0;
               nxt_err_acc  = 1'b0;
               nxt_in_ready = 1'b0;
               nxt_state    = SUB;
            end
         end
         SUB: begin
            nxt_work[int'(idx)*4 +: 4] = dd;
            nxt_brw     = dbout;
            nxt_err_acc = fin_err;
            if (idx == LAST) begin
               nxt_idx    = '0;
               nxt_borrow = dbout & ~fin_err;
`ifdef BCD_SUB_SIGNMAG_EN
               if (dbout && !fin_err) begin
                  nxt_brw   = 1'b0;
                  nxt_state = NEG;
               end else
`endif
               begin
                  nxt_diff      = fin_err ? '0 : nxt_work;
                  nxt_err       = fin_err;
                  nxt_out_valid = 1'b1;
                  nxt_state     = DONE;
               end
            end else begin
               nxt_idx = idx + 1'b1;
            end
         end
`ifdef BCD_SUB_SIGNMAG_EN
         NEG: begin
            nxt_work[int'(idx)*4 +: 4] = dd;
            nxt_brw = dbout;
            if (idx == LAST) begin
               nxt_idx       = '0;
               nxt_diff      = nxt_work;
               nxt_err       = 1'b0;
               nxt_out_valid = 1'b1;
               nxt_state     = DONE;
            end else begin
               nxt_idx = idx + 1'b1;
            end
         end
`endif
         DONE: begin
            if (out_ready) begin
               nxt_out_valid = 1'b0;
               nxt_in_ready  = 1'b1;
               nxt_state     = IDLE;
            end
         end
         default: begin
            nxt_state     = IDLE;
            nxt_in_ready  = 1'b1;
            nxt_out_valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_r       <= '0;
         b_r       <= '0;
         work      <= '0;
         idx       <= '0;
         brw       <= 1'b0;
         err_acc   <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         diff      <= '0;
         borrow    <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= nxt_state;
         a_r       <= nxt_a;
         b_r       <= nxt_b;
         work      <= nxt_work;
         idx       <= nxt_idx;
         brw       <= nxt_brw;
         err_acc   <= nxt_err_acc;
         in_ready  <= nxt_in_ready;
         out_valid <= nxt_out_valid;
         diff      <= nxt_diff;
         borrow    <= nxt_borrow;
         err       <= nxt_err;
      end
   end

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Scoreboard bench for bcd_sub_serial: randomized operands checked against an integer-arithmetic model.
module tb_bcd_sub_serial;

   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, out_valid, out_ready, borrow, err;
   logic [W-1:0]  a, b, diff;

   typedef struct {
      logic [W-1:0] diff;
      logic         borrow;
      logic         err;
      int           lat;
      int           acc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   hold_left = 0;
   bit   rdy_rand = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bcd_sub_serial #(.DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .err       (err)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
      end
   endfunction

   function automatic logic [W-1:0] to_bcd(int n);
      logic [W-1:0] v = '0;
      for (int i = 0; i < DIGITS; i++) begin
         v[i*4 +: 4] = 4'(n % 10);
         n = n / 10;
      end
      return v;
   endfunction

   // Reference: decode both operands to integers and subtract.
   function automatic exp_t model(logic [W-1:0] av, logic [W-1:0] bv, int acc);
      exp_t e;
      int   ai = 0, bi = 0, r, p = 1;
      bit   bad = 0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (av[i*4 +: 4] > 9 || bv[i*4 +: 4] > 9) bad = 1;
         ai = ai * 10 + int'(av[i*4 +: 4]);
         bi = bi * 10 + int'(bv[i*4 +: 4]);
         p  = p * 10;
      end
      e.acc = acc;
      e.lat = DIGITS;
      if (bad) begin
         e.diff = '0; e.borrow = 0; e.err = 1;
      end else begin
         e.err    = 0;
         r        = ai - bi;
         e.borrow = (r < 0);
         if (r < 0) begin
`ifdef BCD_SUB_SIGNMAG_EN
            r     = -r;
            e.lat = 2 * DIGITS;
`else
            r = p + r;
`endif
         end
         e.diff = to_bcd(r);
      end
      return e;
   endfunction

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] v;
      for (int i = 0; i < DIGITS; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) v[$urandom_range(0, DIGITS-1)*4 +: 4] = 4'($urandom_range(10, 15));
      return v;
   endfunction

   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; a = av; b = bv;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
      end else begin
         q.push_back(model(av, bv, cyc + 1));
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((q.size() != 0 || out_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) chk("drain_timeout", 32'(q.size()), 32'd0);
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (hold_left > 0) begin
            out_ready = 1'b0;
            if (out_valid) hold_left--;
         end else if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
         else out_ready = 1'b1;
      end
   end

   // Monitor: pop on each new result, then require it to stay put until taken.
   initial begin
      exp_t cur;
      bit   prev = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) prev = 0;
         else begin
            if (out_valid) begin
               chk("in_ready_in_done", 32'(in_ready), 32'd0);
               if (!prev) begin
                  if (q.size() == 0) chk("unexpected_result", 32'(out_valid), 32'd0);
                  else begin
                     cur = q.pop_front();
                     chk("diff", 32'(diff), 32'(cur.diff));
                     chk("borrow", 32'(borrow), 32'(cur.borrow));
                     chk("err", 32'(err), 32'(cur.err));
                     chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                  end
               end else begin
                  chk("diff_stable", 32'(diff), 32'(cur.diff));
                  chk("borrow_stable", 32'(borrow), 32'(cur.borrow));
               end
            end
            prev = out_valid;
         end
      end
   end

   initial begin
      logic [W-1:0] ra, rb;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_borrow", 32'(borrow), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      send(16'h1234, 16'h0567);
      send(16'h0100, 16'h0001);
      send(16'h0005, 16'h0007);
      send(16'h00A0, 16'h0001);
      send(16'h4321, 16'h4321);
      send(16'h0000, 16'h9999);
      wait_drain();

      // Consumer stalls for 10 cycles while the next operand pair is already waiting.
      hold_left = 10;
      send(16'h1111, 16'h0222);
      send(16'h0042, 16'h0041);
      wait_drain();

      // Reset during the second SUB cycle discards the operation.
      send(16'h4321, 16'h1111);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midsub_in_ready", 32'(in_ready), 32'd1);
      chk("midsub_out_valid", 32'(out_valid), 32'd0);
      chk("midsub_diff", 32'(diff), 32'd0);
      chk("midsub_borrow", 32'(borrow), 32'd0);
      chk("midsub_err", 32'(err), 32'd0);
      q.delete();
      @(negedge clk) rst_n = 1'b1;
      send(16'h9999, 16'h0000);
      wait_drain();

      rdy_rand = 1;
      repeat (80) begin
         ra = rand_bcd();
         rb = ($urandom_range(0, 7) == 0) ? ra : rand_bcd();
         send(ra, rb);
      end
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_sub_serial.md
BCD_SUB_SERIAL -- requirements
Module: bcd_sub_serial

Interface
REQ-001 DIGITS, 4, number of packed BCD digits per operand; legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  4*DIGITS  minuend, packed BCD, digit 0 in [3:0].
REQ-007 b  input  4*DIGITS  subtrahend, packed BCD, same layout.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer takes the result.
REQ-010 diff  output  4*DIGITS  packed BCD result.
REQ-011 borrow  output  1  a < b (final borrow of the subtract pass).
REQ-012 err  output  1  at least one operand digit is greater than 9.

Function
REQ-013 The block SHALL implement the FSM states IDLE, SUB, NEG and DONE, with all outputs registered.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready it SHALL latch a and b, clear the borrow, set digit index 0 and go to SUB.
REQ-015 SUB: one digit per cycle, LSD first; t = a_i - b_i - brw; if t<0 then d_i = t+10 and brw=1, else d_i = t and brw=0.
REQ-016 After DIGITS SUB cycles, borrow SHALL equal the final brw; the next state is NEG if NEG is enabled (REQ-026) and brw=1, otherwise DONE.
REQ-017 Latency: with accept at edge t0, out_valid SHALL be high after edge t0+DIGITS (no NEG), or after edge t0+2*DIGITS (with NEG).
REQ-018 DONE: out_valid=1 and diff/borrow/err held stable; on out_valid&out_ready the FSM returns to IDLE and out_valid drops the next cycle.
REQ-019 in_ready SHALL be 0 in SUB, NEG and DONE; there is no pipelining and no accept in the same cycle as result release.
REQ-020 out_ready is ignored outside DONE; in_valid is ignored outside IDLE.
REQ-021 Any latched digit >9 in a or b SHALL set err=1 and force diff=0 and borrow=0 in DONE; NEG SHALL be skipped.
REQ-022 a == b SHALL give diff=0 and borrow=0.
REQ-023 The digit index SHALL wrap to 0 at each pass boundary.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, in_ready=1, out_valid=0, diff=0, borrow=0, err=0, internal brw=0 and digit index 0.
REQ-025 Reset mid-SUB, mid-NEG or in DONE SHALL discard the operation with no partial result presented; the first accept after release SHALL behave as from power-up.

Configuration
REQ-026 Macro BCD_SUB_SIGNMAG_EN defined: NEG pass enabled; on borrow=1, diff SHALL be replaced by its magnitude, computed digit-serially as 0 - r_i - brw with the REQ-015 rule over DIGITS cycles; borrow then means the result is negative.
REQ-027 Macro BCD_SUB_SIGNMAG_EN undefined: NEG state and its logic SHALL be absent; on borrow=1, diff is the raw ten's complement (10^DIGITS - (b-a)).

Structure
REQ-028 The shared package bcd_pkg SHALL hold the FSM state enum, BCD_MAX=9 and BCD_RADIX=10.
REQ-029 The single-digit combinational step (digit, digit, borrow-in -> digit, borrow-out, invalid flag) SHALL be the sub-module bcd_digit_sub, shared by the SUB and NEG passes.

Verification (DIGITS=4)
REQ-030 a=0x1234, b=0x0567 -> diff=0x0667, borrow=0, err=0, out_valid 4 edges after accept.
REQ-031 a=0x0100, b=0x0001 -> diff=0x0099, borrow=0 (borrow ripple through zeros).
REQ-032 a=0x0005, b=0x0007 -> macro off: diff=0x9998, borrow=1 at 4 edges; macro on: diff=0x0002, borrow=1 at 8 edges.
REQ-033 a=0x00A0, b=0x0001 -> err=1, diff=0x0000, borrow=0.
REQ-034 Hold out_ready=0 for 10 cycles in DONE -> out_valid and diff stable and in_ready=0; a new in_valid is not accepted until one cycle after release.
REQ-035 Pulse rst_n low at the 2nd SUB cycle -> all outputs reach reset values immediately; a following a=0x9999, b=0x0000 gives diff=0x9999.
